data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 46 ++++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/data_mem_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: bus widths, CPU opcodes,
// controller state encoding, stack pointer defaults and the registered access
// descriptor carried from arbitration into the issue/capture phases.
package data_mem_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SP_W   = 16;

  // Empty-stack pointer and lowest legal pointer value.
  localparam logic [SP_W-1:0] SP_RESET_DEFAULT = 16'h0200;
  localparam logic [SP_W-1:0] SP_LIMIT_DEFAULT = 16'h0100;

  // Requester slots on the arbiter.
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DMA = 1;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } cpu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // Control side of an accepted access, latched when the winner is picked.
  typedef struct packed {
    logic dma;     // 1 = DMA owns the access, 0 = CPU
    logic rd;      // access reads memory and needs a CAPTURE phase
    logic sp_dec;  // successful push: decrement sp at end of ISSUE
    logic sp_inc;  // successful pop: increment sp at end of ISSUE
    logic ovf;     // rejected push
    logic unf;     // rejected pop
  } acc_ctl_t;

  // Stack slot addressed by a pointer value.
  function automatic logic [ADDR_W-1:0] sp_addr(input logic [SP_W-1:0] v);
    return v[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req[1:0]  - request vector (bit 0 CPU, bit 1 DMA)
//   grant[1:0]- one-hot grant, combinational from req and the last winner
// The last-winner record advances whenever a grant is issued; the caller
// gates req so that grants only appear when an access can be accepted.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // 1 = DMA won the last grant, so the CPU wins the next tie.
  logic last_dma_q;

  // Lone requester wins; a tie goes to whoever did not win last.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_dma_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma_q <= 1'b1;
    end else if (|grant) begin
      last_dma_q <= grant[REQ_DMA];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: arbitrates CPU and DMA accesses onto a single-port
// DataMemory and implements a hardware stack (push/pop) for the CPU.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   cpu_req/op/addr/wdata             - CPU request (load/store/push/pop)
//   cpu_gnt, cpu_rvalid, cpu_rdata    - CPU accept pulse and read return
//   dma_req/we/addr/wdata             - DMA request (load/store only)
//   dma_gnt, dma_rvalid, dma_rdata    - DMA accept pulse and read return
//   sp_set, sp_value                  - CPU write of the stack pointer
//   mem_address/data_in/store/load    - DataMemory command (ISSUE cycle only)
//   mem_data_out                      - DataMemory read data, one cycle later
//   sp, stack_ovf, stack_unf          - stack pointer and sticky error flags
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter logic [SP_W-1:0] SP_RESET = SP_RESET_DEFAULT,
  parameter logic [SP_W-1:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic [1:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  input  logic              sp_set,
  input  logic [SP_W-1:0]   sp_value,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_store,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_data_out,

  output logic [SP_W-1:0]   sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  state_e            state_q;
  acc_ctl_t          acc_q;
  acc_ctl_t          acc_d;

  logic              cpu_gnt_q;
  logic              dma_gnt_q;
  logic              cpu_rvalid_q;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              mem_store_q;
  logic              mem_load_q;
  logic [SP_W-1:0]   sp_q;
  logic              stack_ovf_q;
  logic              stack_unf_q;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              store_d;
  logic              load_d;
  logic [SP_W-1:0]   sp_eff_d;

  logic [1:0]        arb_req;
  logic [1:0]        grant;

  // Requests are only arbitrated while idle, so the arbiter's history only
  // advances on accepted accesses.
  assign arb_req = (state_q == IDLE) ? {dma_req, cpu_req} : 2'b00;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .grant (grant)
  );

  // Decode the winner into a memory command. Stack checks use the pointer
  // value that will be live during ISSUE, so an sp_set in the same cycle is
  // honoured consistently for both the address and the later sp update.
  always_comb begin
    acc_d    = '0;
    addr_d   = '0;
    wdata_d  = '0;
    store_d  = 1'b0;
    load_d   = 1'b0;
    sp_eff_d = sp_set ? sp_value : sp_q;

    if (grant[REQ_DMA]) begin
      // DMA carries no stack opcode: only plain load/store are possible.
      acc_d.dma = 1'b1;
      acc_d.rd  = ~dma_we;
      addr_d    = dma_addr;
      wdata_d   = dma_wdata;
      store_d   = dma_we;
      load_d    = ~dma_we;
    end else if (grant[REQ_CPU]) begin
      unique case (cpu_op_e'(cpu_op))
        OP_LOAD: begin
          acc_d.rd = 1'b1;
          addr_d   = cpu_addr;
          load_d   = 1'b1;
        end
        OP_STORE: begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          store_d = 1'b1;
        end
        OP_PUSH: begin
          if (sp_eff_d == SP_LIMIT) begin
            acc_d.ovf = 1'b1;
          end else begin
            acc_d.sp_dec = 1'b1;
            addr_d       = sp_addr(sp_eff_d - SP_W'(1));
            wdata_d      = cpu_wdata;
            store_d      = 1'b1;
          end
        end
        OP_POP: begin
          if (sp_eff_d == SP_RESET) begin
            acc_d.unf = 1'b1;
          end else begin
            acc_d.rd     = 1'b1;
            acc_d.sp_inc = 1'b1;
            addr_d       = sp_addr(sp_eff_d);
            load_d       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Controller FSM with registered outputs. Pulses and the memory command
  // default low each cycle and are raised only for the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_store_q   <= 1'b0;
      mem_load_q    <= 1'b0;
      sp_q          <= SP_RESET;
      stack_ovf_q   <= 1'b0;
      stack_unf_q   <= 1'b0;
    end else begin
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_store_q   <= 1'b0;
      mem_load_q    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            state_q       <= ISSUE;
            acc_q         <= acc_d;
            cpu_gnt_q     <= grant[REQ_CPU];
            dma_gnt_q     <= grant[REQ_DMA];
            mem_address_q <= addr_d;
            mem_data_in_q <= wdata_d;
            mem_store_q   <= store_d;
            mem_load_q    <= load_d;
          end
        end
        ISSUE: begin
          if (acc_q.sp_dec) sp_q <= sp_q - SP_W'(1);
          if (acc_q.sp_inc) sp_q <= sp_q + SP_W'(1);
          if (acc_q.ovf) stack_ovf_q <= 1'b1;
          if (acc_q.unf) stack_unf_q <= 1'b1;
          if (acc_q.rd) begin
            state_q      <= CAPTURE;
            cpu_rvalid_q <= ~acc_q.dma;
            dma_rvalid_q <= acc_q.dma;
          end else begin
            state_q <= IDLE;
          end
        end
        CAPTURE: begin
          state_q <= IDLE;
          if (cpu_rvalid_q) cpu_rdata_q <= mem_data_out;
          if (dma_rvalid_q) dma_rdata_q <= mem_data_out;
        end
        default: state_q <= IDLE;
      endcase

      // A direct pointer write overrides any push/pop update this cycle.
      if (sp_set) sp_q <= sp_value;
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign dma_gnt     = dma_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign dma_rvalid  = dma_rvalid_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_store   = mem_store_q;
  assign mem_load    = mem_load_q;
  assign sp          = sp_q;
  assign stack_ovf   = stack_ovf_q;
  assign stack_unf   = stack_unf_q;

  // Memory data only exists during CAPTURE, so it is passed straight through
  // on the strobe cycle and held from the capture register afterwards.
  assign cpu_rdata = cpu_rvalid_q ? mem_data_out : cpu_rdata_q;
  assign dma_rdata = dma_rvalid_q ? mem_data_out : dma_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed scenarios plus randomized CPU/DMA
// traffic checked against a transaction-level memory and stack model.
module tb_data_mem_ctrl;
  import data_mem_pkg::*;

  localparam logic [15:0] SP_RST = 16'h0200;
  localparam logic [15:0] SP_LIM = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_gnt, cpu_rvalid;
  logic [1:0]  cpu_op;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [8:0]  dma_addr;
  logic [15:0] dma_wdata, dma_rdata;
  logic        sp_set;
  logic [15:0] sp_value;
  logic [8:0]  mem_address;
  logic [15:0] mem_data_in, mem_data_out;
  logic        mem_store, mem_load;
  logic [15:0] sp;
  logic        stack_ovf, stack_unf;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .sp_set(sp_set), .sp_value(sp_value),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_store(mem_store), .mem_load(mem_load), .mem_data_out(mem_data_out),
    .sp(sp), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  // DataMemory stand-in: synchronous write, registered read.
  logic [15:0] ram [512];
  logic        ram_clear;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 512; i++) ram[i] <= 16'h0000;
    end else if (mem_store) begin
      ram[mem_address] <= mem_data_in;
    end
    if (mem_load) mem_data_out <= ram[mem_address];
  end

  // Bus activity monitors.
  int store_cnt = 0, load_cnt = 0, both_cnt = 0, outside_cnt = 0;
  always @(negedge clk) begin
    if (mem_store) store_cnt++;
    if (mem_load) load_cnt++;
    if (mem_store && mem_load) both_cnt++;
    if ((mem_store || mem_load) && dut.state_q != ISSUE) outside_cnt++;
  end

  // Reference model state.
  logic [15:0] ref_mem [512];
  logic [15:0] ref_sp;
  logic        ref_ovf, ref_unf;
  logic [15:0] last_cpu_rd, last_dma_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ref_sp      = SP_RST;
    ref_ovf     = 1'b0;
    ref_unf     = 1'b0;
    last_cpu_rd = 16'h0000;
    last_dma_rd = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; sp_set = 1'b0;
    @(posedge clk); #1;
    check("rst_sp", sp, SP_RST);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_sp(input logic [15:0] v);
    @(negedge clk);
    sp_set = 1'b1; sp_value = v;
    @(posedge clk); #1;
    sp_set = 1'b0;
    ref_sp = v;
    check("sp_set", sp, ref_sp);
  endtask

  // One CPU transaction. ssmode: 0 none, 1 sp_set alongside the request,
  // 2 sp_set during the grant cycle.
  task automatic cpu_xfer(input logic [1:0] op, input logic [8:0] addr,
                          input logic [15:0] wd, input int ssmode, input logic [15:0] sv);
    logic       exp_st, exp_ld;
    logic [8:0] exp_a;
    exp_st = 1'b0; exp_ld = 1'b0; exp_a = 9'h000;
    if (ssmode == 1) ref_sp = sv;
    case (op)
      2'b00: begin exp_ld = 1'b1; exp_a = addr; end
      2'b01: begin exp_st = 1'b1; exp_a = addr; ref_mem[addr] = wd; end
      2'b10: begin
        if (ref_sp == SP_LIM) ref_ovf = 1'b1;
        else begin
          ref_sp = ref_sp - 16'd1;
          exp_st = 1'b1; exp_a = ref_sp[8:0]; ref_mem[exp_a] = wd;
        end
      end
      default: begin
        if (ref_sp == SP_RST) ref_unf = 1'b1;
        else begin
          exp_ld = 1'b1; exp_a = ref_sp[8:0];
          ref_sp = ref_sp + 16'd1;
        end
      end
    endcase
    if (exp_ld) last_cpu_rd = ref_mem[exp_a];
    if (ssmode == 2) ref_sp = sv;

    @(negedge clk);
    cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wdata = wd;
    if (ssmode == 1) begin sp_set = 1'b1; sp_value = sv; end
    @(posedge clk); #1;
    check("cpu_gnt", cpu_gnt, 1);
    check("cpu_xfer_dma_gnt", dma_gnt, 0);
    check("cpu_mem_store", mem_store, exp_st);
    check("cpu_mem_load", mem_load, exp_ld);
    if (exp_st || exp_ld) check("cpu_mem_address", mem_address, exp_a);
    if (exp_st) check("cpu_mem_data_in", mem_data_in, wd);
    @(negedge clk);
    cpu_req = 1'b0; cpu_op = 2'($urandom); cpu_addr = 9'($urandom);
    sp_set = (ssmode == 2); sp_value = sv;
    @(posedge clk); #1;
    sp_set = 1'b0;
    check("cpu_gnt_pulse", cpu_gnt, 0);
    check("cpu_rvalid", cpu_rvalid, exp_ld);
    check("cpu_rdata", cpu_rdata, last_cpu_rd);
    check("cpu_sp", sp, ref_sp);
    check("cpu_ovf", stack_ovf, ref_ovf);
    check("cpu_unf", stack_unf, ref_unf);
    if (exp_ld) begin
      @(posedge clk); #1;
      check("cpu_rvalid_pulse", cpu_rvalid, 0);
      check("cpu_rdata_hold", cpu_rdata, last_cpu_rd);
    end
  endtask

  task automatic dma_xfer(input logic we, input logic [8:0] addr, input logic [15:0] wd);
    if (we) ref_mem[addr] = wd;
    else last_dma_rd = ref_mem[addr];
    @(negedge clk);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    @(posedge clk); #1;
    check("dma_gnt", dma_gnt, 1);
    check("dma_xfer_cpu_gnt", cpu_gnt, 0);
    check("dma_mem_store", mem_store, we);
    check("dma_mem_load", mem_load, !we);
    check("dma_mem_address", mem_address, addr);
    if (we) check("dma_mem_data_in", mem_data_in, wd);
    @(negedge clk);
    dma_req = 1'b0; dma_addr = 9'($urandom);
    @(posedge clk); #1;
    check("dma_rvalid", dma_rvalid, !we);
    check("dma_rdata", dma_rdata, last_dma_rd);
    check("dma_cpu_rvalid", cpu_rvalid, 0);
    if (!we) begin
      @(posedge clk); #1;
      check("dma_rvalid_pulse", dma_rvalid, 0);
    end
  endtask

  function automatic logic [8:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 9'($urandom_range(0, 15));
    return 9'($urandom_range(496, 511));
  endfunction

  function automatic logic [15:0] rnd_sp();
    case ($urandom_range(0, 4))
      0: return SP_LIM;
      1: return SP_LIM + 16'd1;
      2: return SP_RST - 16'd1;
      3: return SP_RST;
      default: return 16'($urandom_range(256, 512));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, ng;
    logic [1:0] gv;
    rst = 1'b1; ram_clear = 1'b1;
    cpu_req = 1'b0; cpu_op = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    sp_set = 1'b0; sp_value = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0000;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    ram_clear = 1'b0;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_mem_store", mem_store, 0);
    check("rst_mem_load", mem_load, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_sp0", sp, SP_RST);
    check("rst_ovf", stack_ovf, 0);
    check("rst_unf", stack_unf, 0);
    check("rst_state0", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Store then load back.
    cpu_xfer(OP_STORE, 9'h001, 16'hAAAA, 0, 16'h0);
    cpu_xfer(OP_LOAD,  9'h001, 16'h0000, 0, 16'h0);

    // Push then pop after reset.
    do_reset();
    cpu_xfer(OP_PUSH, 9'h000, 16'hF0F0, 0, 16'h0);
    cpu_xfer(OP_POP,  9'h000, 16'h0000, 0, 16'h0);

    // Pop on an empty stack.
    do_reset();
    l0 = load_cnt;
    cpu_xfer(OP_POP, 9'h000, 16'h0000, 0, 16'h0);
    check("unf_no_load", load_cnt - l0, 0);

    // Push at the limit.
    set_sp(16'h0100);
    s0 = store_cnt;
    cpu_xfer(OP_PUSH, 9'h000, 16'h1234, 0, 16'h0);
    check("ovf_no_store", store_cnt - s0, 0);

    // sp_set racing a push: in the grant cycle, and alongside the request.
    set_sp(16'h0180);
    cpu_xfer(OP_PUSH, 9'h000, 16'hBEEF, 2, 16'h0150);
    cpu_xfer(OP_PUSH, 9'h000, 16'hCAFE, 1, 16'h01C0);
    cpu_xfer(OP_POP,  9'h000, 16'h0000, 2, 16'h0120);

    // Both requesters held: grants alternate starting with the CPU.
    do_reset();
    ref_mem[9'h005] = 16'h1111;
    ref_mem[9'h006] = 16'h2222;
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = OP_STORE; cpu_addr = 9'h005; cpu_wdata = 16'h1111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h006; dma_wdata = 16'h2222;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      @(posedge clk); #1;
      if (cpu_gnt || dma_gnt) begin
        gv = (ng % 2 == 0) ? 2'b10 : 2'b01;
        check("rr_order", {cpu_gnt, dma_gnt}, gv);
        ng++;
      end
    end
    check("rr_grant_count", ng, 4);
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;
    cpu_xfer(OP_LOAD, 9'h005, 16'h0, 0, 16'h0);
    dma_xfer(1'b0, 9'h006, 16'h0);

    // Reset during ISSUE of a DMA load: the read never returns.
    cpu_xfer(OP_PUSH, 9'h000, 16'h5A5A, 0, 16'h0);
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h006;
    @(posedge clk); #1;
    check("issue_rst_gnt", dma_gnt, 1);
    @(negedge clk);
    dma_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("issue_rst_rvalid", dma_rvalid, 0);
    check("issue_rst_sp", sp, SP_RST);
    check("issue_rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("issue_rst_no_rvalid", dma_rvalid, 0);

    // Reset during CAPTURE of a DMA load.
    cpu_xfer(OP_PUSH, 9'h000, 16'h6B6B, 0, 16'h0);
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h006;
    @(posedge clk); #1;
    check("cap_gnt", dma_gnt, 1);
    @(negedge clk);
    dma_req = 1'b0;
    @(posedge clk); #1;
    check("cap_rvalid", dma_rvalid, 1);
    check("cap_rdata", dma_rdata, ref_mem[9'h006]);
    rst = 1'b1;
    @(posedge clk); #1;
    check("cap_rst_rvalid", dma_rvalid, 0);
    check("cap_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("cap_rst_sp", sp, SP_RST);
    check("cap_rst_rdata", dma_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        int m;
        m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
        cpu_xfer(2'($urandom_range(0, 3)), rnd_addr(), 16'($urandom), m, rnd_sp());
      end else if (r <= 8) begin
        dma_xfer(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom));
      end else begin
        set_sp(rnd_sp());
      end
    end

    check("store_load_overlap", both_cnt, 0);
    check("mem_cmd_outside_issue", outside_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
